rsv_entry_alloc: RTL and testbench

- Upstream companion of the reservation-station age matrix.
- Owns the per-entry valid vector of the reservation station (RSV).
- Each cycle it picks up to 4 free entry indices for dispatch, marks them valid, and frees entries as they issue.
- Drives the dispatch valid/free-entry indices and the entry-valid vector that the age matrix and issue select consume; handles flush and dispatch backpressure.

---
 rtl/rsv_entry_alloc_pkg.sv | 22 ++
 rtl/rsv_entry_alloc_if.sv | 38 +++
 rtl/rsv_entry_alloc_free_pick.sv | 33 +++
 rtl/rsv_entry_alloc.sv | 105 ++++++++++
 tb/tb_rsv_entry_alloc.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rsv_entry_alloc_pkg.sv
// Shared reservation-station definitions.
// Contents: the RSV geometry constants, index/vector/count types, and the
// index->onehot helper. The age matrix uses the same helper.
package rsv_entry_alloc_pkg;

  localparam int RSV_ENTRY_NUMS = 64;
  localparam int RSV_IDX_WIDTH  = 6;
  localparam int DSP_WIDTH      = 4;
  localparam int ISS_WIDTH      = 2;

  typedef logic [RSV_IDX_WIDTH-1:0]  rsv_idx_t;
  typedef logic [RSV_ENTRY_NUMS-1:0] rsv_vec_t;
  typedef logic [RSV_IDX_WIDTH:0]    rsv_cnt_t;

  function automatic rsv_vec_t idx2onehot(rsv_idx_t idx);
    rsv_vec_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rsv_entry_alloc_if.sv
// Dispatch and issue handshake between the pipeline front and the RSV.
//   master : dispatch/issue side. It drives the requests and issue frees,
//            and it receives the grants and the assigned entries.
//   slave  : the RSV allocator.
// Signals:
//   i_dsp_req_vld               per-slot dispatch request
//   o_dsp_rsv_rdy               RSV can take a full dispatch group
//   o_dsp_rsv_vld               granted slots
//   o_dsp_rsv_free_entry_0..3   entry assigned to each slot
//   i_iss_vld, i_iss_entry_0/1  issue-port deallocations
interface rsv_entry_alloc_if;
  import rsv_entry_alloc_pkg::*;

  logic [DSP_WIDTH-1:0] i_dsp_req_vld;
  logic                 o_dsp_rsv_rdy;
  logic [DSP_WIDTH-1:0] o_dsp_rsv_vld;
  rsv_idx_t             o_dsp_rsv_free_entry_0;
  rsv_idx_t             o_dsp_rsv_free_entry_1;
  rsv_idx_t             o_dsp_rsv_free_entry_2;
  rsv_idx_t             o_dsp_rsv_free_entry_3;
  logic [ISS_WIDTH-1:0] i_iss_vld;
  rsv_idx_t             i_iss_entry_0;
  rsv_idx_t             i_iss_entry_1;

  modport master (
    output i_dsp_req_vld, i_iss_vld, i_iss_entry_0, i_iss_entry_1,
    input  o_dsp_rsv_rdy, o_dsp_rsv_vld,
           o_dsp_rsv_free_entry_0, o_dsp_rsv_free_entry_1,
           o_dsp_rsv_free_entry_2, o_dsp_rsv_free_entry_3
  );

  modport slave (
    input  i_dsp_req_vld, i_iss_vld, i_iss_entry_0, i_iss_entry_1,
    output o_dsp_rsv_rdy, o_dsp_rsv_vld,
           o_dsp_rsv_free_entry_0, o_dsp_rsv_free_entry_1,
           o_dsp_rsv_free_entry_2, o_dsp_rsv_free_entry_3
  );
endinterface

// File: rtl/rsv_entry_alloc_free_pick.sv
// rsv_free_pick: a combinational cascaded priority-find. It returns the
// DSP_WIDTH lowest zero bits of the valid vector.
//   vld_vec    : registered entry-valid vector
//   pick_idx   : index of the k-th lowest free entry (0 when not found)
//   pick_found : pick k exists
// Each stage masks the entries taken by earlier stages before it searches.
module rsv_free_pick
  import rsv_entry_alloc_pkg::*;
(
  input  rsv_vec_t                                vld_vec,
  output logic [DSP_WIDTH-1:0][RSV_IDX_WIDTH-1:0] pick_idx,
  output logic [DSP_WIDTH-1:0]                    pick_found
);

  rsv_vec_t taken;

  always_comb begin
    taken      = vld_vec;
    pick_idx   = '0;
    pick_found = '0;
    for (int k = 0; k < DSP_WIDTH; k++) begin
      // A descending scan leaves the lowest free index in pick_idx.
      for (int i = RSV_ENTRY_NUMS-1; i >= 0; i--) begin
        if (!taken[i]) begin
          pick_idx[k]   = RSV_IDX_WIDTH'(i);
          pick_found[k] = 1'b1;
        end
      end
      if (pick_found[k]) taken = taken | idx2onehot(pick_idx[k]);
    end
  end

endmodule

// File: rtl/rsv_entry_alloc.sv
// rsv_entry_alloc: owns the RSV entry-valid vector. Each cycle it grants up
// to DSP_WIDTH dispatch slots onto the lowest free entries, and it frees the
// entries named by the issue ports.
//   clk, rst               clock, synchronous active-high reset
//   i_*_flush              trap / mispredict / ld-st replay flush
//   bus (slave)            dispatch request/grant and issue deallocation
//   o_rsv_entry_vld_vec    registered valid vector
//   o_rsv_free_cnt         registered free-entry count
//   o_rsv_empty/full       decode of the free count
module rsv_entry_alloc
  import rsv_entry_alloc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_csr_trap_flush,
  input  logic                i_exu_mis_flush,
  input  logic                i_exu_ls_flush,
  rsv_entry_alloc_if.slave    bus,
  output rsv_vec_t            o_rsv_entry_vld_vec,
  output rsv_cnt_t            o_rsv_free_cnt,
  output logic                o_rsv_empty,
  output logic                o_rsv_full
);

  rsv_vec_t vld_vec, vld_nxt, alloc_vec, dealloc_vec;
  rsv_cnt_t free_cnt, cnt_nxt, gnt_cnt;
  logic     rdy, rdy_nxt, flush, d0, d1;
  logic [DSP_WIDTH-1:0]                    grant, pick_found;
  logic [DSP_WIDTH-1:0][RSV_IDX_WIDTH-1:0] pick_idx;

  rsv_free_pick u_pick (
    .vld_vec    (vld_vec),
    .pick_idx   (pick_idx),
    .pick_found (pick_found)
  );

  assign flush = i_csr_trap_flush | i_exu_mis_flush | i_exu_ls_flush;
  // rdy guarantees that DSP_WIDTH picks exist, so a grant always lands on a
  // found pick. A group is therefore granted whole or not at all.
  assign grant = bus.i_dsp_req_vld & {DSP_WIDTH{rdy & ~flush}};

  // Only valid entries can be freed. When both ports name the same entry,
  // the entry is counted once.
  assign d0 = bus.i_iss_vld[0] & vld_vec[bus.i_iss_entry_0];
  assign d1 = bus.i_iss_vld[1] & vld_vec[bus.i_iss_entry_1]
            & ~(d0 & (bus.i_iss_entry_0 == bus.i_iss_entry_1));

  always_comb begin
    alloc_vec = '0;
    gnt_cnt   = '0;
    for (int k = 0; k < DSP_WIDTH; k++) begin
      if (grant[k]) alloc_vec = alloc_vec | idx2onehot(pick_idx[k]);
      gnt_cnt = gnt_cnt + rsv_cnt_t'(grant[k]);
    end
    dealloc_vec = (d0 ? idx2onehot(bus.i_iss_entry_0) : '0)
                | (d1 ? idx2onehot(bus.i_iss_entry_1) : '0);
    vld_nxt = (vld_vec | alloc_vec) & ~dealloc_vec;
    cnt_nxt = free_cnt - gnt_cnt + rsv_cnt_t'(d0) + rsv_cnt_t'(d1);
    if (flush) begin
      vld_nxt = '0;
      cnt_nxt = rsv_cnt_t'(RSV_ENTRY_NUMS);
    end
    rdy_nxt = flush | (cnt_nxt >= rsv_cnt_t'(DSP_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_vec  <= '0;
      free_cnt <= rsv_cnt_t'(RSV_ENTRY_NUMS);
      rdy      <= 1'b1;
    end else begin
      vld_vec  <= vld_nxt;
      free_cnt <= cnt_nxt;
      rdy      <= rdy_nxt;
    end
  end

  // An issue of a non-valid entry is tolerated but reported. The count
  // invariant must always hold.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (bus.i_iss_vld[0])
        assert (vld_vec[bus.i_iss_entry_0])
          else $warning("rsv: issue port 0 names non-valid entry %0d", bus.i_iss_entry_0);
      if (bus.i_iss_vld[1])
        assert (vld_vec[bus.i_iss_entry_1])
          else $warning("rsv: issue port 1 names non-valid entry %0d", bus.i_iss_entry_1);
    end
    if (!rst)
      assert (int'(free_cnt) == RSV_ENTRY_NUMS - $countones(vld_vec))
        else $error("rsv: free_cnt %0d disagrees with valid vector", free_cnt);
  end

  assign bus.o_dsp_rsv_rdy          = rdy;
  assign bus.o_dsp_rsv_vld          = grant;
  assign bus.o_dsp_rsv_free_entry_0 = pick_idx[0];
  assign bus.o_dsp_rsv_free_entry_1 = pick_idx[1];
  assign bus.o_dsp_rsv_free_entry_2 = pick_idx[2];
  assign bus.o_dsp_rsv_free_entry_3 = pick_idx[3];
  assign o_rsv_entry_vld_vec        = vld_vec;
  assign o_rsv_free_cnt             = free_cnt;
  assign o_rsv_empty                = (free_cnt == rsv_cnt_t'(RSV_ENTRY_NUMS));
  assign o_rsv_full                 = (free_cnt == '0);

endmodule

// File: tb/tb_rsv_entry_alloc.sv
module tb_rsv_entry_alloc;
  import rsv_entry_alloc_pkg::*;

  logic clk = 1'b0;
  logic rst, trap_fl, mis_fl, ls_fl;
  rsv_vec_t vld_vec;
  rsv_cnt_t free_cnt;
  logic empty, full;

  rsv_entry_alloc_if bus();

  rsv_entry_alloc dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_csr_trap_flush    (trap_fl),
    .i_exu_mis_flush     (mis_fl),
    .i_exu_ls_flush      (ls_fl),
    .bus                 (bus),
    .o_rsv_entry_vld_vec (vld_vec),
    .o_rsv_free_cnt      (free_cnt),
    .o_rsv_empty         (empty),
    .o_rsv_full          (full)
  );

  always #5 clk = ~clk;

  // Behavioural model. It holds the set of occupied entries and the ready bit.
  bit m_vld [RSV_ENTRY_NUMS];
  bit m_rdy;
  bit m_init;
  int n_cmp, n_bad;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < RSV_ENTRY_NUMS; i++) if (!m_vld[i]) n++;
    return n;
  endfunction

  // The k-th lowest free entry, or 0 when fewer than k+1 entries are free.
  function automatic int m_pick(int k);
    int seen = 0;
    for (int i = 0; i < RSV_ENTRY_NUMS; i++)
      if (!m_vld[i]) begin
        if (seen == k) return i;
        seen++;
      end
    return 0;
  endfunction

  function automatic logic [63:0] m_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < RSV_ENTRY_NUMS; i++) v[i] = m_vld[i];
    return v;
  endfunction

  function automatic int dut_pick(int k);
    case (k)
      0: return int'(bus.o_dsp_rsv_free_entry_0);
      1: return int'(bus.o_dsp_rsv_free_entry_1);
      2: return int'(bus.o_dsp_rsv_free_entry_2);
      default: return int'(bus.o_dsp_rsv_free_entry_3);
    endcase
  endfunction

  task automatic compare_all();
    logic [3:0] egnt;
    bit fl = trap_fl | mis_fl | ls_fl;
    for (int k = 0; k < DSP_WIDTH; k++) egnt[k] = bus.i_dsp_req_vld[k] & m_rdy & !fl;
    for (int k = 0; k < DSP_WIDTH; k++) chk($sformatf("pick%0d", k), 64'(dut_pick(k)), 64'(m_pick(k)));
    chk("grant", 64'(bus.o_dsp_rsv_vld), 64'(egnt));
    chk("rdy", 64'(bus.o_dsp_rsv_rdy), 64'(m_rdy));
    chk("vld_vec", vld_vec, m_vec());
    chk("free_cnt", 64'(free_cnt), 64'(m_free()));
    chk("empty", 64'(empty), 64'(m_free() == RSV_ENTRY_NUMS));
    chk("full", 64'(full), 64'(m_free() == 0));
  endtask

  task automatic update_model();
    int picks[DSP_WIDTH];
    bit pre[RSV_ENTRY_NUMS];
    bit fl = trap_fl | mis_fl | ls_fl;
    if (rst || fl) begin
      foreach (m_vld[i]) m_vld[i] = 0;
      m_rdy  = 1;
      m_init = m_init | rst;
      return;
    end
    pre = m_vld;
    for (int k = 0; k < DSP_WIDTH; k++) picks[k] = m_pick(k);
    // Frees apply only to entries that were valid before this cycle.
    if (bus.i_iss_vld[0] && pre[bus.i_iss_entry_0]) m_vld[bus.i_iss_entry_0] = 0;
    if (bus.i_iss_vld[1] && pre[bus.i_iss_entry_1]) m_vld[bus.i_iss_entry_1] = 0;
    if (m_rdy)
      for (int k = 0; k < DSP_WIDTH; k++) if (bus.i_dsp_req_vld[k]) m_vld[picks[k]] = 1;
    m_rdy = (m_free() >= DSP_WIDTH);
  endtask

  // One clock. Outputs are compared at the falling edge. The model then
  // advances with the same inputs that the DUT samples at the rising edge.
  task automatic step();
    @(negedge clk);
    if (m_init) compare_all();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit [2:0] fl, bit [3:0] req, bit [1:0] iv, int e0, int e1);
    rst = r;
    trap_fl = fl[0]; mis_fl = fl[1]; ls_fl = fl[2];
    bus.i_dsp_req_vld = req;
    bus.i_iss_vld     = iv;
    bus.i_iss_entry_0 = rsv_idx_t'(e0);
    bus.i_iss_entry_1 = rsv_idx_t'(e1);
  endtask

  initial begin
    int vl[$];
    int e0, e1;
    bit [1:0] iv;
    bit [2:0] fl;
    n_cmp = 0; n_bad = 0; m_init = 0; m_rdy = 1;

    drive(1, 0, 0, 0, 0, 0); step(); step();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("rst vld_vec", vld_vec, 64'h0);
    chk("rst free_cnt", 64'(free_cnt), 64);
    chk("rst rdy", 64'(bus.o_dsp_rsv_rdy), 1);
    chk("rst empty/full", {62'h0, empty, full}, 64'b10);

    // A first full group takes entries 0..3.
    drive(0, 0, 4'hF, 0, 0, 0); #1;
    chk("t1 picks", {40'h0, 6'(dut_pick(3)), 6'(dut_pick(2)), 6'(dut_pick(1)), 6'(dut_pick(0))},
        {40'h0, 6'd3, 6'd2, 6'd1, 6'd0});
    chk("t1 grant", 64'(bus.o_dsp_rsv_vld), 64'hF);
    step();
    chk("t1 vld_vec", vld_vec, 64'hF);
    chk("t1 free_cnt", 64'(free_cnt), 60);

    // After 15 full groups a 0101 group leaves 2 free entries, and rdy drops.
    for (int i = 0; i < 14; i++) step();
    drive(0, 0, 4'b0101, 0, 0, 0); step();
    chk("t2 free_cnt", 64'(free_cnt), 2);
    chk("t2 rdy/full", {62'h0, bus.o_dsp_rsv_rdy, full}, 64'b00);
    drive(0, 0, 4'hF, 0, 0, 0); #1;
    chk("t2 no grant", 64'(bus.o_dsp_rsv_vld), 0);
    step();

    // Fill to full, then free 5, 9, 20 and 33.
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 4'hF, 0, 0, 0);
    for (int i = 0; i < 16; i++) step();
    chk("t3 full", {62'h0, full, bus.o_dsp_rsv_rdy}, 64'b10);
    drive(0, 0, 0, 2'b11, 5, 9); step();
    chk("t3 free_cnt 2", 64'(free_cnt), 2);
    chk("t3 rdy 0", 64'(bus.o_dsp_rsv_rdy), 0);
    drive(0, 0, 0, 2'b11, 20, 33); step();
    chk("t3 free_cnt 4", 64'(free_cnt), 4);
    chk("t3 rdy 1", 64'(bus.o_dsp_rsv_rdy), 1);
    chk("t3 picks", {40'h0, 6'(dut_pick(3)), 6'(dut_pick(2)), 6'(dut_pick(1)), 6'(dut_pick(0))},
        {40'h0, 6'd33, 6'd20, 6'd9, 6'd5});

    // Dispatch together with a free of entry 40. Entry 40 is not reused in
    // the same cycle.
    drive(0, 0, 4'hF, 2'b01, 40, 0); #1;
    chk("t4 grant", 64'(bus.o_dsp_rsv_vld), 64'hF);
    step();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("t4 free_cnt", 64'(free_cnt), 1);
    chk("t4 pick0", 64'(dut_pick(0)), 40);

    // Both ports free entry 7, which counts once. A repeat free of 7 is ignored.
    drive(0, 0, 0, 2'b11, 7, 7); step();
    chk("t5 dup free", 64'(free_cnt), 2);
    drive(0, 0, 0, 2'b01, 7, 0); step();
    chk("t5 invalid free", 64'(free_cnt), 2);

    // Flushes and a reset during dispatch.
    drive(0, 3'b010, 4'hF, 0, 0, 0); #1;
    chk("t6 flush grant", 64'(bus.o_dsp_rsv_vld), 0);
    step();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("t6 flush state", {vld_vec[56:0], free_cnt}, {57'h0, 7'd64});
    chk("t6 flush rdy", 64'(bus.o_dsp_rsv_rdy), 1);
    drive(0, 0, 4'hF, 0, 0, 0); step();
    drive(0, 3'b100, 4'hF, 2'b01, 0, 0); step();
    chk("t6 ls flush cnt", 64'(free_cnt), 64);
    drive(0, 0, 4'hF, 0, 0, 0); step();
    drive(1, 0, 4'hF, 2'b01, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("t6 rst vld_vec", vld_vec, 0);
    chk("t6 rst cnt/rdy", {56'h0, free_cnt, bus.o_dsp_rsv_rdy}, {56'h0, 7'd64, 1'b1});

    // Random phase. Issues name only currently valid entries.
    for (int c = 0; c < 3000; c++) begin
      vl.delete();
      foreach (m_vld[i]) if (m_vld[i]) vl.push_back(i);
      iv = 0; e0 = 0; e1 = 0;
      if (vl.size() > 0) begin
        iv = 2'($urandom_range(0, 3));
        e0 = vl[$urandom_range(0, vl.size()-1)];
        e1 = ($urandom_range(0, 7) == 0) ? e0 : vl[$urandom_range(0, vl.size()-1)];
      end
      fl = 0;
      if ($urandom_range(0, 99) == 0) fl = 3'(1 << $urandom_range(0, 2));
      drive($urandom_range(0, 799) == 0, fl,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, iv, e0, e1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
